// File: rtl/lorenz_pkg.sv
// Shared constants and types for the lorenz oscillator core and its run controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lorenz_pkg;

    // Sample word format: signed Q10.21, identical to the core state registers.
    localparam int Width      = 32;
    localparam int FracBits   = 21;

    // Clocks per core iteration while the core start input is held high.
    localparam int IterCycles = 2;

    typedef enum logic [1:0] {
        IDLE,
        WARMUP,
        RUN,
        DRAIN
    } lorenz_ctrl_state_t;

endpackage

// File: rtl/lorenz_out_reg.sv
// One-entry valid/ready output register with a capture port and a drop indication.
// Latency: capture to m_valid_o is 1 cycle; a transfer and a new capture may share a cycle.
// Backpressure: holds data while m_ready_i=0; a capture offered while full is refused (overrun_o).
//
// Ports: cap_* is the producer side (cap_rdy_o = slot empty or emptying this cycle);
//        m_* is the consumer valid/ready side; flush_i empties the slot and wins over capture;
//        overrun_o is a same-cycle pulse when a capture is refused.
module lorenz_out_reg
    import lorenz_pkg::*;
#(
    parameter int DataW = 3 * Width
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             cap_vld_i,
    input  logic [DataW-1:0] cap_dat_i,
    input  logic             cap_last_i,
    output logic             cap_rdy_o,
    output logic             overrun_o,
    output logic             m_valid_o,
    input  logic             m_ready_i,
    output logic [DataW-1:0] m_dat_o,
    output logic             m_last_o
);

    logic             vld_q, vld_d;
    logic             last_q, last_d;
    logic [DataW-1:0] dat_q, dat_d;

    // The slot can take a new sample when empty or when it is being drained this cycle.
    assign cap_rdy_o = !vld_q || m_ready_i;
    assign overrun_o = cap_vld_i && !cap_rdy_o;

    always_comb begin
        vld_d  = vld_q;
        last_d = last_q;
        dat_d  = dat_q;
        if (vld_q && m_ready_i) begin
            vld_d  = 1'b0;
            last_d = 1'b0;
        end
        if (cap_vld_i && cap_rdy_o) begin
            vld_d  = 1'b1;
            last_d = cap_last_i;
            dat_d  = cap_dat_i;
        end
        if (flush_i) begin
            vld_d  = 1'b0;
            last_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q  <= 1'b0;
            last_q <= 1'b0;
            dat_q  <= '0;
        end else begin
            vld_q  <= vld_d;
            last_q <= last_d;
            dat_q  <= dat_d;
        end
    end

    assign m_valid_o = vld_q;
    assign m_last_o  = last_q;
    assign m_dat_o   = dat_q;

endmodule

// File: rtl/lorenz_ctrl.sv
// Run controller for the lorenz core: start, warm-up discard, decimation, sample streaming, stop.
// Latency: run_i -> core_start_o 1 cycle; sample tick -> m_valid_o 1 cycle; last transfer -> done_o 1 cycle.
// Backpressure: one-entry output slot; sample ticks that find it full are dropped and flagged on overrun_o.
//
// Ports: run_i/abort_i and n_samples_i/decim_i/warmup_i come from config logic (config latched on
//        an accepted run); core_start_o and xn_i/yn_i/zn_i connect to the core; m_* is the sample
//        stream; busy_o/done_o/overrun_o are status.
module lorenz_ctrl
    import lorenz_pkg::*;
#(
    parameter int Width      = lorenz_pkg::Width,
    parameter int IterCycles = lorenz_pkg::IterCycles
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             run_i,
    input  logic             abort_i,
    input  logic [31:0]      n_samples_i,
    input  logic [15:0]      decim_i,
    input  logic [31:0]      warmup_i,
    output logic             core_start_o,
    input  logic [Width-1:0] xn_i,
    input  logic [Width-1:0] yn_i,
    input  logic [Width-1:0] zn_i,
    output logic             m_valid_o,
    input  logic             m_ready_i,
    output logic [Width-1:0] m_x_o,
    output logic [Width-1:0] m_y_o,
    output logic [Width-1:0] m_z_o,
    output logic             m_last_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             overrun_o
);

    localparam int             PhW    = (IterCycles > 1) ? $clog2(IterCycles) : 1;
    localparam logic [PhW-1:0] PhLast = PhW'(IterCycles - 1);

    lorenz_ctrl_state_t state_q, state_d;
    logic               core_start_q, core_start_d;
    logic               done_q, done_d;
    logic               overrun_q, overrun_d;
    logic [PhW-1:0]     phase_q, phase_d;
    logic [31:0]        warm_cnt_q, warm_cnt_d;
    logic [15:0]        dec_cnt_q, dec_cnt_d;
    logic [31:0]        smp_cnt_q, smp_cnt_d;
    logic [31:0]        n_q, n_d;
    logic [15:0]        decim_q, decim_d;
    logic [31:0]        warmup_q, warmup_d;

    logic               tick;
    logic               sample_tick;
    logic               cap_vld;
    logic               cap_last;
    logic               cap_rdy;
    logic               drop;
    logic               m_valid;
    logic               m_last;
    logic [3*Width-1:0] m_dat;

    // Core outputs are valid on the last phase of each iteration.
    assign tick        = core_start_q && (phase_q == PhLast);
    // decim of 0 or 1 keeps every iteration.
    assign sample_tick = tick && (state_q == RUN) &&
                         ((decim_q <= 16'd1) || (dec_cnt_q == decim_q - 16'd1));

    always_comb begin
        state_d      = state_q;
        core_start_d = core_start_q;
        done_d       = 1'b0;
        overrun_d    = overrun_q | drop;
        warm_cnt_d   = warm_cnt_q;
        dec_cnt_d    = dec_cnt_q;
        smp_cnt_d    = smp_cnt_q;
        n_d          = n_q;
        decim_d      = decim_q;
        warmup_d     = warmup_q;
        cap_vld      = 1'b0;
        cap_last     = 1'b0;

        unique case (state_q)
            IDLE: begin
                core_start_d = 1'b0;
                if (run_i) begin
                    n_d        = n_samples_i;
                    decim_d    = decim_i;
                    warmup_d   = warmup_i;
                    overrun_d  = 1'b0;
                    warm_cnt_d = '0;
                    dec_cnt_d  = '0;
                    smp_cnt_d  = '0;
                    if (n_samples_i == 32'd0) begin
                        done_d = 1'b1;
                    end else begin
                        core_start_d = 1'b1;
                        state_d      = (warmup_i == 32'd0) ? RUN : WARMUP;
                    end
                end
            end
            WARMUP: begin
                if (tick) begin
                    if (warm_cnt_q == warmup_q - 32'd1) begin
                        state_d   = RUN;
                        dec_cnt_d = '0;
                    end else begin
                        warm_cnt_d = warm_cnt_q + 32'd1;
                    end
                end
            end
            RUN: begin
                if (sample_tick) begin
                    dec_cnt_d = '0;
                    cap_vld   = 1'b1;
                    // Compare against n-1 so n = 0xFFFFFFFF finishes without the count wrapping.
                    cap_last  = (smp_cnt_q == n_q - 32'd1);
                    if (cap_rdy) begin
                        smp_cnt_d = smp_cnt_q + 32'd1;
                        if (cap_last) begin
                            core_start_d = 1'b0;
                            state_d      = DRAIN;
                        end
                    end
                end else if (tick) begin
                    dec_cnt_d = dec_cnt_q + 16'd1;
                end
            end
            DRAIN: begin
                // Only the last sample can be in the slot here.
                if (m_valid && m_ready_i) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort beats everything, including a run request and a completing drain.
        if (abort_i) begin
            state_d      = IDLE;
            core_start_d = 1'b0;
            done_d       = 1'b0;
            overrun_d    = overrun_q;
        end

        // Phase restarts at 0 on every rising edge of core_start.
        phase_d = (core_start_q && core_start_d) ?
                  ((phase_q == PhLast) ? '0 : phase_q + 1'b1) : '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            core_start_q <= 1'b0;
            done_q       <= 1'b0;
            overrun_q    <= 1'b0;
            phase_q      <= '0;
            warm_cnt_q   <= '0;
            dec_cnt_q    <= '0;
            smp_cnt_q    <= '0;
            n_q          <= '0;
            decim_q      <= '0;
            warmup_q     <= '0;
        end else begin
            state_q      <= state_d;
            core_start_q <= core_start_d;
            done_q       <= done_d;
            overrun_q    <= overrun_d;
            phase_q      <= phase_d;
            warm_cnt_q   <= warm_cnt_d;
            dec_cnt_q    <= dec_cnt_d;
            smp_cnt_q    <= smp_cnt_d;
            n_q          <= n_d;
            decim_q      <= decim_d;
            warmup_q     <= warmup_d;
        end
    end

    lorenz_out_reg #(
        .DataW (3 * Width)
    ) u_out_reg (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .flush_i    (abort_i),
        .cap_vld_i  (cap_vld),
        .cap_dat_i  ({xn_i, yn_i, zn_i}),
        .cap_last_i (cap_last),
        .cap_rdy_o  (cap_rdy),
        .overrun_o  (drop),
        .m_valid_o  (m_valid),
        .m_ready_i  (m_ready_i),
        .m_dat_o    (m_dat),
        .m_last_o   (m_last)
    );

    assign core_start_o = core_start_q;
    assign m_valid_o    = m_valid;
    assign m_last_o     = m_last;
    assign m_x_o        = m_dat[3*Width-1 -: Width];
    assign m_y_o        = m_dat[2*Width-1 -: Width];
    assign m_z_o        = m_dat[Width-1 -: Width];
    assign busy_o       = (state_q != IDLE);
    assign done_o       = done_q;
    assign overrun_o    = overrun_q;

endmodule

// File: tb/tb_lorenz_ctrl.sv
// Bench for lorenz_ctrl: emulated core, randomized runs, queue scoreboard with a separate monitor.
// Latency: n/a.
// Backpressure: consumer ready is driven from a per-run pattern (random or directed).
module tb_lorenz_ctrl;

    localparam int IC  = 2;
    localparam int LEN = 600;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        run_i = 1'b0;
    logic        abort_i = 1'b0;
    logic [31:0] n_samples_i = '0;
    logic [15:0] decim_i = '0;
    logic [31:0] warmup_i = '0;
    logic        core_start_o;
    logic [31:0] xn_i = '0, yn_i = '0, zn_i = '0;
    logic        m_valid_o;
    logic        m_ready_i = 1'b0;
    logic [31:0] m_x_o, m_y_o, m_z_o;
    logic        m_last_o, busy_o, done_o, overrun_o;

    lorenz_ctrl #(.Width(32), .IterCycles(IC)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .run_i(run_i), .abort_i(abort_i),
        .n_samples_i(n_samples_i), .decim_i(decim_i), .warmup_i(warmup_i),
        .core_start_o(core_start_o), .xn_i(xn_i), .yn_i(yn_i), .zn_i(zn_i),
        .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
        .m_x_o(m_x_o), .m_y_o(m_y_o), .m_z_o(m_z_o), .m_last_o(m_last_o),
        .busy_o(busy_o), .done_o(done_o), .overrun_o(overrun_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] x, y, z;
        logic        last;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          n_chk = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int unsigned run_seed = 0;
    int          ccnt = 0;
    int unsigned core_iter = 0;
    bit          ovr_prev = 0;
    bit          rdy_pat[LEN];

    always @(posedge clk_i) cyc <= cyc + 1;

    function automatic logic [31:0] core_val(input int unsigned seed, input int unsigned it,
                                             input int unsigned lane);
        return (seed * 32'h9E3779B1) ^ (it * 32'h85EBCA6B) ^ ((lane + 1) * 32'hC2B2AE35);
    endfunction

    // Core stand-in: iteration k (1-based since start rose) is presented during its IC cycles.
    always @(posedge clk_i) begin
        #1;
        if (core_start_o) begin
            core_iter = ccnt / IC + 1;
            xn_i = core_val(run_seed, core_iter, 0);
            yn_i = core_val(run_seed, core_iter, 1);
            zn_i = core_val(run_seed, core_iter, 2);
            ccnt++;
        end else begin
            ccnt = 0;
        end
    end

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] expv);
        n_chk++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    endtask

    // Monitor: every transfer must match the oldest expected sample, including its cycle.
    always @(negedge clk_i) begin
        if (rst_ni && m_valid_o && m_ready_i) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL spurious_xfer: got x=%0h last=%0b at cycle %0d, expected no transfer",
                         m_x_o, m_last_o, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("sample", {m_x_o, m_y_o, m_z_o, m_last_o, cyc},
                    {mon_e.x, mon_e.y, mon_e.z, mon_e.last, mon_e.cyc});
            end
        end
    end

    // One run, relative cycle 0 = the cycle run_i is high. ab < 0 means no abort.
    task automatic do_run(input int w, input int d, input logic [31:0] n, input int prob,
                          input int free_at, input int ab);
        int deff, t, h, hprev, t_last, h_last, end_rel, win_end;
        int rise, fall, done_cnt, done_rel, rise_exp, fall_exp, base;
        int unsigned cnt, k;
        bit ovr, aborted, exp_done, exp_ovr;
        exp_t e;

        aborted  = (ab >= 0);
        deff     = (d <= 1) ? 1 : d;
        run_seed = $urandom;
        base     = cyc;
        for (int c = 0; c < LEN; c++)
            rdy_pat[c] = (c >= free_at) || ($urandom_range(0, 99) < prob);

        // Reference: sample k falls on iteration w + k*deff, i.e. cycle (w + k*deff)*IC.
        // It is taken if the slot's previous occupant has been handed off by then.
        cnt = 0; k = 1; hprev = -1; t_last = -1; h_last = -1; ovr = 0;
        while (n != 0 && cnt < n) begin
            t = (w + int'(k) * deff) * IC;
            if (aborted && t >= ab) break;
            if (t > LEN - 20) begin
                n_chk++;
                $display("FAIL model_bound: got tick cycle %0d, expected below %0d", t, LEN - 20);
                break;
            end
            if (hprev <= t) begin
                h = t + 1;
                while (h < LEN && !rdy_pat[h]) h++;
                if (h >= LEN && !aborted) begin
                    n_chk++;
                    $display("FAIL model_bound: got no ready after cycle %0d, expected one", t);
                    break;
                end
                cnt++;
                e.x = core_val(run_seed, w + k * deff, 0);
                e.y = core_val(run_seed, w + k * deff, 1);
                e.z = core_val(run_seed, w + k * deff, 2);
                e.last = (cnt == n);
                e.cyc  = base + h;
                if (!aborted || h <= ab) exp_q.push_back(e);
                hprev = h;
                if (e.last) begin t_last = t; h_last = h; end
            end else begin
                ovr = 1;
            end
            k++;
        end

        exp_done = aborted ? (n != 0 && h_last >= 0 && h_last < ab) : 1'b1;
        exp_ovr  = (aborted && ab == 0) ? ovr_prev : ovr;
        rise_exp = (n != 0 && !(aborted && ab == 0)) ? 1 : -1;
        fall_exp = (rise_exp < 0) ? -1 :
                   ((t_last >= 0 && (!aborted || t_last + 1 <= ab)) ? t_last + 1 : ab + 1);
        if (n == 0 || (aborted && ab == 0)) win_end = -1;
        else if (aborted) win_end = (h_last >= 0 && h_last < ab) ? h_last : ab;
        else win_end = h_last;
        end_rel = aborted ? ab + 3 : ((n == 0) ? 3 : h_last + 3);
        if (end_rel > LEN - 1) end_rel = LEN - 1;

        rise = -1; fall = -1; done_cnt = 0; done_rel = -1;
        for (int rel = 0; rel <= end_rel; rel++) begin
            if (rel > 0) begin
                if (done_o) begin done_cnt++; done_rel = rel; end
                if (core_start_o && rise < 0) rise = rel;
                if (!core_start_o && rise >= 0 && fall < 0) fall = rel;
                if (aborted && rel == ab + 1) begin
                    chk("abort_valid", m_valid_o, 0);
                    chk("abort_busy", busy_o, 0);
                end
            end
            // Extra run_i pulses and config churn while busy must be ignored.
            run_i = (rel == 0) || (rel <= win_end && $urandom_range(0, 3) == 0);
            if (rel == 0) begin
                n_samples_i = n; decim_i = 16'(d); warmup_i = w;
            end else begin
                n_samples_i = $urandom; decim_i = 16'($urandom); warmup_i = $urandom;
            end
            abort_i   = aborted && (rel == ab);
            m_ready_i = rdy_pat[rel];
            @(posedge clk_i); #1;
        end
        run_i = 0; abort_i = 0; m_ready_i = 0;
        n_samples_i = '0; decim_i = '0; warmup_i = '0;

        chk("done_count", done_cnt, exp_done);
        if (exp_done) chk("done_cycle", done_rel, (n == 0) ? 1 : h_last + 1);
        chk("start_rise", rise, rise_exp);
        chk("start_fall", fall, fall_exp);
        chk("overrun", overrun_o, exp_ovr);
        chk("idle_after_run", {busy_o, m_valid_o, core_start_o}, 0);
        chk("queue_drained", exp_q.size(), 0);
        ovr_prev = exp_ovr;
    endtask

    initial begin
        repeat (3) @(posedge clk_i);
        #1;
        chk("in_reset", {core_start_o, m_valid_o, m_last_o, busy_o, done_o, overrun_o}, 0);
        #2 rst_ni = 1'b1;
        repeat (10) @(posedge clk_i);
        #1;
        chk("idle_core_start", core_start_o, 0);
        chk("idle_valid", m_valid_o, 0);
        chk("idle_last", m_last_o, 0);
        chk("idle_busy", busy_o, 0);
        chk("idle_done", done_o, 0);
        chk("idle_overrun", overrun_o, 0);
        chk("idle_data", {m_x_o, m_y_o, m_z_o}, 0);

        do_run(0, 1, 4, 100, 0, -1);          // basic cadence, always ready
        do_run(5, 3, 2, 100, 0, -1);          // warm-up and decimation
        do_run(0, 0, 3, 100, 0, -1);          // decim 0 acts as 1
        do_run(0, 1, 3, 0, 30, -1);           // stalled consumer, drops, then completion
        do_run(0, 1, 5, 0, 1000, 10);         // abort with a pending sample
        do_run(1, 2, 3, 100, 0, -1);          // clean restart after abort
        do_run(0, 1, 0, 100, 0, -1);          // zero samples
        do_run(0, 1, 2, 100, 0, 0);           // abort and run together in IDLE
        do_run(0, 1, 32'hFFFF_FFFF, 70, 400, 40);
        for (int i = 0; i < 20; i++)
            do_run($urandom_range(0, 6), $urandom_range(0, 4), $urandom_range(0, 6),
                   $urandom_range(25, 100), 400, -1);

        // Asynchronous reset in the middle of a stalled run.
        run_i = 1; n_samples_i = 10; decim_i = 1; warmup_i = 0; m_ready_i = 0;
        @(posedge clk_i); #1;
        run_i = 0;
        repeat (6) @(posedge clk_i);
        #1;
        chk("pre_reset_active", {core_start_o, m_valid_o, busy_o, overrun_o}, 4'b1111);
        #2 rst_ni = 1'b0;
        #1;
        chk("async_reset", {core_start_o, m_valid_o, m_last_o, busy_o, done_o, overrun_o}, 0);
        @(posedge clk_i);
        #3 rst_ni = 1'b1;
        @(posedge clk_i); #1;
        ovr_prev = 0;
        do_run(2, 2, 3, 60, 400, -1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
